// File: rtl/arith_pkg.sv
// Shared types for the iterative arithmetic unit.
// Used by the shift-add multiplier and the restoring divider.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WORK  = 2'b01,
    FINAL = 2'b10
  } fsm_state_t;

  function automatic int cnt_width(input int len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring trial subtract: shift in the next dividend bit,
// subtract the divisor when it fits, emit the quotient bit.
module div_step #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] rem,
  input  logic           q_msb,
  input  logic [LEN-1:0] divisor,
  output logic [LEN-1:0] rem_next,
  output logic           q_bit
);

  logic [LEN:0]   t;
  logic [LEN-1:0] diff;

  // Trial subtract; the difference always fits LEN bits when it is taken.
  always_comb begin
    t        = {rem, q_msb};
    diff     = t[LEN-1:0] - divisor;
    q_bit    = (t >= {1'b0, divisor});
    rem_next = q_bit ? diff : t[LEN-1:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands.
module restoring_divider
  import arith_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [LEN-1:0] dividend,
  input  logic [LEN-1:0] divisor,
  input  logic           start,
  output logic [LEN-1:0] quotient,
  output logic [LEN-1:0] remainder,
  output logic           div_zero,
  output logic           busy,
  output logic           finish
);

  localparam int CW = cnt_width(LEN);

  fsm_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0] qacc_q, qacc_d;
  logic [LEN-1:0] racc_q, racc_d;
  logic [LEN-1:0] dvs_q, dvs_d;
  logic           zero_q, zero_d;
  logic [LEN-1:0] quo_q, quo_d;
  logic [LEN-1:0] rmd_q, rmd_d;
  logic           dz_q, dz_d;
  logic           fin_q, fin_d;
`ifdef DIVIDER_SIGNED_EN
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [LEN-1:0] orig_q, orig_d;
`endif

  logic [LEN-1:0] step_rem;
  logic           step_bit;

  div_step #(.LEN(LEN)) u_step (
    .rem      (racc_q),
    .q_msb    (qacc_q[LEN-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  // Next-state, datapath and result logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    qacc_d  = qacc_q;
    racc_d  = racc_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    fin_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    orig_d  = orig_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WORK;
          cnt_d   = CW'(LEN-1);
          racc_d  = '0;
          zero_d  = (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
          qacc_d  = dividend[LEN-1] ? -dividend : dividend;
          dvs_d   = divisor[LEN-1] ? -divisor : divisor;
          qneg_d  = dividend[LEN-1] ^ divisor[LEN-1];
          rneg_d  = dividend[LEN-1];
          orig_d  = dividend;
`else
          qacc_d  = dividend;
          dvs_d   = divisor;
`endif
        end
      end
      WORK: begin
        racc_d = step_rem;
        qacc_d = {qacc_q[LEN-2:0], step_bit};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FINAL;
      end
      FINAL: begin
        state_d = IDLE;
        fin_d   = 1'b1;
        dz_d    = zero_q;
        if (zero_q) begin
          quo_d = '1;
`ifdef DIVIDER_SIGNED_EN
          rmd_d = orig_q;
`else
          rmd_d = racc_q;
`endif
        end else begin
`ifdef DIVIDER_SIGNED_EN
          quo_d = qneg_q ? -qacc_q : qacc_q;
          rmd_d = rneg_q ? -racc_q : racc_q;
`else
          quo_d = qacc_q;
          rmd_d = racc_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CW'(LEN-1);
      qacc_q  <= '0;
      racc_q  <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
      fin_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      orig_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qacc_q  <= qacc_d;
      racc_q  <= racc_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
      fin_q   <= fin_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      orig_q  <= orig_d;
`endif
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;
  assign finish    = fin_q;
  assign busy      = (state_q == WORK) || (state_q == FINAL);

endmodule
